oq_regs_pkt_count: RTL and testbench
====================================

Name: oq_regs_pkt_count

Overview:
- Per-output-queue packet counter that feeds the queue empty-evaluation stage.
- Store events (dst side) increment a queue's count; remove events (src side) decrement it.
- Each update produces a one-cycle done pulse carrying the new count, with the queue index registered alongside it, so the downstream empty evaluator can latch the index on update and the value on done.
- Also provides a registered count read port for the register block, and sticky overflow/underflow flags.

Parameters:
- SRAM_ADDR_WIDTH, 19, SRAM word address width.
- CTRL_WIDTH, 8, control bits per word; used to derive MIN_PKT.
- NUM_OUTPUT_QUEUES, 8, number of queues.
- NUM_OQ_WIDTH, log2(NUM_OUTPUT_QUEUES), queue index width.
- MIN_PKT, 60/CTRL_WIDTH+1, minimum packet size in words.
- PKTS_IN_RAM_WIDTH, log2((2**SRAM_ADDR_WIDTH)/MIN_PKT), width of each count.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- dst_update  in  1  packet stored pulse.
- dst_oq  in  NUM_OQ_WIDTH  queue index for the store.
- src_update  in  1  packet removed pulse.
- src_oq  in  NUM_OQ_WIDTH  queue index for the remove.
- initialize  in  1  clear-queue pulse.
- initialize_oq  in  NUM_OQ_WIDTH  queue index to clear.
- dst_num_pkts_in_q  out  PKTS_IN_RAM_WIDTH  count after the store.
- dst_num_pkts_in_q_done  out  1  dst result valid pulse.
- src_num_pkts_in_q  out  PKTS_IN_RAM_WIDTH  count after the remove.
- src_num_pkts_in_q_done  out  1  src result valid pulse.
- rd_req  in  1  register read request.
- rd_oq  in  NUM_OQ_WIDTH  queue index to read.
- rd_data  out  PKTS_IN_RAM_WIDTH  read result.
- rd_ack  out  1  read result valid pulse.
- overflow  out  NUM_OUTPUT_QUEUES  sticky per-queue overflow flag.
- underflow  out  NUM_OUTPUT_QUEUES  sticky per-queue underflow flag.

Behaviour:
- Storage: flop array count[NUM_OUTPUT_QUEUES], each PKTS_IN_RAM_WIDTH bits. No RAM, no read latency.
- Reset:
  - all counts 0;
  - both done outputs 0, rd_ack 0;
  - all num_pkts outputs and rd_data 0;
  - overflow and underflow all 0.
- Latency: an update presented in cycle N is written into the array at the end of cycle N. The done pulse and value are registered at the same edge, so they are visible during cycle N+1 for exactly one cycle.
- Store (dst_update=1) only: count[dst_oq] <= count[dst_oq]+1; dst_num_pkts_in_q <= the new value.
- Remove (src_update=1) only: count[src_oq] <= count[src_oq]-1; src_num_pkts_in_q <= the new value.
- Store and remove in the same cycle:
  - Different queues: both updates are applied independently.
  - Same queue: the store is ordered before the remove. The count is unchanged; dst output = old+1; src output = old.
- Saturation:
  - Increment at all-ones: the count holds, overflow[q] sets, and dst output = all-ones.
  - Decrement at 0: the count holds at 0, underflow[q] sets, and src output = 0.
  - For a same-queue simultaneous pair, saturation is evaluated on the ordered intermediate values.
- Initialize:
  - Sets count[initialize_oq] <= 0 and clears overflow/underflow for that queue.
  - Initialize has priority over updates to the same queue in the same cycle. The done pulses still fire, but the reported value is 0.
  - Updates to other queues proceed normally.
- Done outputs: each done is a registered copy of its update strobe, and each value register is loaded only when its strobe is high. When no update occurs, the value holds its last result.
- Back-to-back: one update per side per cycle, indefinitely. There is no back-pressure.
- Read port:
  - rd_req in cycle N returns rd_data = count[rd_oq] as it stands at the start of cycle N (pre-update) and rd_ack=1 during cycle N+1.
  - Reads never stall updates.
- Reset asserted mid-stream: everything returns to reset values at that edge, and any in-flight done pulses are dropped.

Decomposition:
- Shared package holds:
  - the log2 function;
  - the derived widths MIN_PKT and PKTS_IN_RAM_WIDTH;
  - the queue index width.
- One natural sub-module, oq_pkt_count_next: combinational next-count and saturation logic for a single queue. Inputs: old count, inc, dec, init. Outputs: dst value, src value, new count, ovf, udf. Instantiated per queue via generate.

Test Plan:
- Reset, then 3 dst_update to queue 2 in consecutive cycles -> dst done pulses in the next 3 cycles with values 1, 2, 3; rd queue 2 afterwards returns 3.
- Queue 5 at count 4; dst_update and src_update to queue 5 in the same cycle -> dst value 5, src value 4, final count 4, both dones high for one cycle.
- src_update to empty queue 1 -> src value 0, underflow[1]=1, count stays 0; initialize queue 1 -> underflow[1]=0.
- Force queue 0 to all-ones via repeated stores; one further store -> value all-ones, overflow[0]=1.
- initialize queue 3 (count 7) in the same cycle as dst_update to queue 3 and dst_update to... (dst is single) -> dst done value 0, count[3]=0. Concurrent src_update to queue 6 (count 2) -> src value 1.
- Reset asserted in the cycle after an update -> no done pulse observed, all counts read 0.

Source files
------------

// File: rtl/oq_regs_pkt_count_pkg.sv
// Shared definitions for the output-queue packet counter: the log2 helper and
// the widths derived from the SRAM geometry and the number of output queues.
package oq_regs_pkt_count_pkg;

   // Number of bits needed to index 'value' items (ceiling log2, log2(1) = 0).
   function automatic int log2(input longint value);
      int res;
      res = 0;
      while ((longint'(1) << res) < value) begin
         res = res + 1;
      end
      return res;
   endfunction

   // Smallest packet in words: 60 bytes of payload plus one control word.
   function automatic int calc_min_pkt(input int ctrl_width);
      return 60 / ctrl_width + 1;
   endfunction

   // Width of a count able to hold the largest number of packets the SRAM fits.
   function automatic int calc_pkts_in_ram_width(input int sram_addr_width,
                                                 input int ctrl_width);
      return log2((longint'(1) << sram_addr_width) / calc_min_pkt(ctrl_width));
   endfunction

   localparam int DEFAULT_SRAM_ADDR_WIDTH   = 19;
   localparam int DEFAULT_CTRL_WIDTH        = 8;
   localparam int DEFAULT_NUM_OUTPUT_QUEUES = 8;

   localparam int DEFAULT_NUM_OQ_WIDTH      = log2(DEFAULT_NUM_OUTPUT_QUEUES);
   localparam int DEFAULT_MIN_PKT           = calc_min_pkt(DEFAULT_CTRL_WIDTH);
   localparam int DEFAULT_PKTS_IN_RAM_WIDTH =
      calc_pkts_in_ram_width(DEFAULT_SRAM_ADDR_WIDTH, DEFAULT_CTRL_WIDTH);

endpackage

// File: rtl/oq_regs_pkt_count_next.sv
// Next-count evaluation for a single queue. A store is applied before a remove
// so that a simultaneous pair on one queue leaves the count unchanged; both
// steps saturate independently and flag the saturation. Clearing the queue
// overrides everything and reports zero on both sides.
module oq_pkt_count_next
   import oq_regs_pkt_count_pkg::*;
#(
   parameter int W = DEFAULT_PKTS_IN_RAM_WIDTH
) (
   input  logic [W-1:0] old_count,
   input  logic         inc,
   input  logic         dec,
   input  logic         init,
   output logic [W-1:0] dst_value,
   output logic [W-1:0] src_value,
   output logic [W-1:0] new_count,
   output logic         ovf,
   output logic         udf
);

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Decrement that sticks at zero instead of wrapping.
   function automatic logic [W-1:0] sat_dec(input logic [W-1:0] v);
      return (v == '0) ? v : v - 1'b1;
   endfunction

   logic [W-1:0] after_store;
   logic [W-1:0] after_remove;

   // Store first, then remove on the intermediate value; clear wins over both.
   always_comb begin
      after_store  = old_count;
      after_remove = old_count;
      ovf          = 1'b0;
      udf          = 1'b0;
      if (inc) begin
         ovf         = &old_count;
         after_store = sat_inc(old_count);
      end
      after_remove = after_store;
      if (dec) begin
         udf          = (after_store == '0);
         after_remove = sat_dec(after_store);
      end
      if (init) begin
         after_store  = '0;
         after_remove = '0;
         ovf          = 1'b0;
         udf          = 1'b0;
      end
   end

   assign dst_value = after_store;
   assign src_value = after_remove;
   assign new_count = after_remove;

endmodule

// File: rtl/oq_regs_pkt_count.sv
// Per-output-queue packet counter. Store events increment, remove events
// decrement, and each update returns a one-cycle done pulse with the new count
// for the downstream empty evaluator. Also serves register reads of any count
// and keeps sticky per-queue overflow/underflow flags.
module oq_regs_pkt_count
   import oq_regs_pkt_count_pkg::*;
#(
   parameter int SRAM_ADDR_WIDTH   = DEFAULT_SRAM_ADDR_WIDTH,
   parameter int CTRL_WIDTH        = DEFAULT_CTRL_WIDTH,
   parameter int NUM_OUTPUT_QUEUES = DEFAULT_NUM_OUTPUT_QUEUES,
   parameter int NUM_OQ_WIDTH      = log2(NUM_OUTPUT_QUEUES),
   parameter int MIN_PKT           = calc_min_pkt(CTRL_WIDTH),
   parameter int PKTS_IN_RAM_WIDTH =
      log2((longint'(1) << SRAM_ADDR_WIDTH) / MIN_PKT)
) (
   input  logic                         clk,
   input  logic                         reset,

   input  logic                         dst_update,
   input  logic [NUM_OQ_WIDTH-1:0]      dst_oq,
   input  logic                         src_update,
   input  logic [NUM_OQ_WIDTH-1:0]      src_oq,
   input  logic                         initialize,
   input  logic [NUM_OQ_WIDTH-1:0]      initialize_oq,

   output logic [PKTS_IN_RAM_WIDTH-1:0] dst_num_pkts_in_q,
   output logic                         dst_num_pkts_in_q_done,
   output logic [PKTS_IN_RAM_WIDTH-1:0] src_num_pkts_in_q,
   output logic                         src_num_pkts_in_q_done,

   input  logic                         rd_req,
   input  logic [NUM_OQ_WIDTH-1:0]      rd_oq,
   output logic [PKTS_IN_RAM_WIDTH-1:0] rd_data,
   output logic                         rd_ack,

   output logic [NUM_OUTPUT_QUEUES-1:0] overflow,
   output logic [NUM_OUTPUT_QUEUES-1:0] underflow
);

   localparam int NQ = NUM_OUTPUT_QUEUES;
   localparam int PW = PKTS_IN_RAM_WIDTH;

   logic [PW-1:0] count      [NQ];
   logic [PW-1:0] dst_value  [NQ];
   logic [PW-1:0] src_value  [NQ];
   logic [PW-1:0] next_count [NQ];

   logic [NQ-1:0] inc_vec;
   logic [NQ-1:0] dec_vec;
   logic [NQ-1:0] init_vec;
   logic [NQ-1:0] ovf_hit;
   logic [NQ-1:0] udf_hit;

   // Each queue decodes which events target it and computes its own next count.
   for (genvar q = 0; q < NQ; q++) begin : g_queue
      assign inc_vec[q]  = dst_update && (dst_oq == NUM_OQ_WIDTH'(q));
      assign dec_vec[q]  = src_update && (src_oq == NUM_OQ_WIDTH'(q));
      assign init_vec[q] = initialize && (initialize_oq == NUM_OQ_WIDTH'(q));

      oq_pkt_count_next #(
         .W (PW)
      ) u_next (
         .old_count (count[q]),
         .inc       (inc_vec[q]),
         .dec       (dec_vec[q]),
         .init      (init_vec[q]),
         .dst_value (dst_value[q]),
         .src_value (src_value[q]),
         .new_count (next_count[q]),
         .ovf       (ovf_hit[q]),
         .udf       (udf_hit[q])
      );
   end

   // Count array: every queue takes its next value each cycle (unchanged when idle).
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int q = 0; q < NQ; q++) begin
            count[q] <= '0;
         end
      end else begin
         for (int q = 0; q < NQ; q++) begin
            count[q] <= next_count[q];
         end
      end
   end

   // Sticky saturation flags; clearing a queue also clears its flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow  <= '0;
         underflow <= '0;
      end else begin
         for (int q = 0; q < NQ; q++) begin
            if (init_vec[q]) begin
               overflow[q]  <= 1'b0;
               underflow[q] <= 1'b0;
            end else begin
               overflow[q]  <= overflow[q]  | ovf_hit[q];
               underflow[q] <= underflow[q] | udf_hit[q];
            end
         end
      end
   end

   // Update results: done mirrors the strobe, value loads only on a strobe and holds otherwise.
   always_ff @(posedge clk) begin
      if (reset) begin
         dst_num_pkts_in_q_done <= 1'b0;
         src_num_pkts_in_q_done <= 1'b0;
         dst_num_pkts_in_q      <= '0;
         src_num_pkts_in_q      <= '0;
      end else begin
         dst_num_pkts_in_q_done <= dst_update;
         src_num_pkts_in_q_done <= src_update;
         if (dst_update) begin
            dst_num_pkts_in_q <= dst_value[dst_oq];
         end
         if (src_update) begin
            src_num_pkts_in_q <= src_value[src_oq];
         end
      end
   end

   // Register read port: returns the count as it stood before this cycle's updates.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ack  <= 1'b0;
         rd_data <= '0;
      end else begin
         rd_ack <= rd_req;
         if (rd_req) begin
            rd_data <= count[rd_oq];
         end
      end
   end

endmodule

// File: tb/tb_oq_regs_pkt_count.sv
// Self-checking bench for oq_regs_pkt_count. Built with a 10-bit SRAM address
// so each count is 7 bits wide and saturation is reachable in a short run.
module tb_oq_regs_pkt_count;

   localparam int NQ   = 8;
   localparam int QW   = 3;
   localparam int PW   = 7;
   localparam int MAXV = 127;

   logic          clk = 1'b0;
   logic          reset;
   logic          dst_update;
   logic [QW-1:0] dst_oq;
   logic          src_update;
   logic [QW-1:0] src_oq;
   logic          initialize;
   logic [QW-1:0] initialize_oq;
   logic [PW-1:0] dst_num_pkts_in_q;
   logic          dst_num_pkts_in_q_done;
   logic [PW-1:0] src_num_pkts_in_q;
   logic          src_num_pkts_in_q_done;
   logic          rd_req;
   logic [QW-1:0] rd_oq;
   logic [PW-1:0] rd_data;
   logic          rd_ack;
   logic [NQ-1:0] overflow;
   logic [NQ-1:0] underflow;

   always #5 clk = ~clk;

   oq_regs_pkt_count #(
      .SRAM_ADDR_WIDTH (10)
   ) dut (
      .clk                    (clk),
      .reset                  (reset),
      .dst_update             (dst_update),
      .dst_oq                 (dst_oq),
      .src_update             (src_update),
      .src_oq                 (src_oq),
      .initialize             (initialize),
      .initialize_oq          (initialize_oq),
      .dst_num_pkts_in_q      (dst_num_pkts_in_q),
      .dst_num_pkts_in_q_done (dst_num_pkts_in_q_done),
      .src_num_pkts_in_q      (src_num_pkts_in_q),
      .src_num_pkts_in_q_done (src_num_pkts_in_q_done),
      .rd_req                 (rd_req),
      .rd_oq                  (rd_oq),
      .rd_data                (rd_data),
      .rd_ack                 (rd_ack),
      .overflow               (overflow),
      .underflow              (underflow)
   );

   typedef struct {
      bit du; int dq;
      bit su; int sq;
      bit iu; int iq;
      bit rr; int rq;
      bit edd; int edv;
      bit esd; int esv;
      bit eak; int erd;
   } vec_t;

   typedef struct {
      bit dd; int dv;
      bit sd; int sv;
      bit ak; int rd;
   } exp_t;

   exp_t sb[$];
   vec_t vt[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   function automatic vec_t mk(bit du, int dq, bit su, int sq, bit iu, int iq,
                               bit rr, int rq, bit edd, int edv, bit esd, int esv,
                               bit eak, int erd);
      vec_t v;
      v.du = du; v.dq = dq; v.su = su; v.sq = sq; v.iu = iu; v.iq = iq;
      v.rr = rr; v.rq = rq; v.edd = edd; v.edv = edv; v.esd = esd; v.esv = esv;
      v.eak = eak; v.erd = erd;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic idle();
      dst_update = 1'b0; dst_oq = '0;
      src_update = 1'b0; src_oq = '0;
      initialize = 1'b0; initialize_oq = '0;
      rd_req = 1'b0; rd_oq = '0;
   endtask

   task automatic drive(input vec_t x);
      exp_t e;
      dst_update = x.du; dst_oq = QW'(x.dq);
      src_update = x.su; src_oq = QW'(x.sq);
      initialize = x.iu; initialize_oq = QW'(x.iq);
      rd_req = x.rr; rd_oq = QW'(x.rq);
      e.dd = x.edd; e.dv = x.edv; e.sd = x.esd; e.sv = x.esv;
      e.ak = x.eak; e.rd = x.erd;
      sb.push_back(e);
   endtask

   task automatic collect();
      exp_t e;
      @(posedge clk);
      #1;
      idle();
      e = sb.pop_front();
      chk("dst_done", int'(dst_num_pkts_in_q_done), int'(e.dd));
      chk("src_done", int'(src_num_pkts_in_q_done), int'(e.sd));
      chk("rd_ack",   int'(rd_ack),                 int'(e.ak));
      if (e.dd) chk("dst_value", int'(dst_num_pkts_in_q), e.dv);
      if (e.sd) chk("src_value", int'(src_num_pkts_in_q), e.sv);
      if (e.ak) chk("rd_data",   int'(rd_data),           e.rd);
   endtask

   task automatic run(input vec_t x);
      drive(x);
      collect();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_dst_done", int'(dst_num_pkts_in_q_done), 0);
      chk("reset_src_done", int'(src_num_pkts_in_q_done), 0);
      chk("reset_rd_ack",   int'(rd_ack), 0);
      chk("reset_dst_val",  int'(dst_num_pkts_in_q), 0);
      chk("reset_src_val",  int'(src_num_pkts_in_q), 0);
      chk("reset_rd_data",  int'(rd_data), 0);
      chk("reset_overflow", int'(overflow), 0);
      chk("reset_underflow", int'(underflow), 0);
      reset = 1'b0;

      //         du dq su sq iu iq rr rq  edd edv esd esv eak erd
      vt.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
      vt.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0));
      vt.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0));
      vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 1, 3));
      vt.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
      vt.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0));
      vt.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0));
      vt.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0));
      vt.push_back(mk(1, 5, 1, 5, 0, 0, 0, 0, 1, 5, 1, 4, 0, 0));
      vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 1, 4));
      vt.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      for (int i = 1; i <= 7; i++)
         vt.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0, 1, i, 0, 0, 0, 0));
      vt.push_back(mk(1, 6, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
      vt.push_back(mk(1, 6, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0));
      vt.push_back(mk(1, 3, 1, 6, 1, 3, 0, 0, 1, 0, 1, 1, 0, 0));
      vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 1, 0));
      vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0, 1, 1));
      vt.push_back(mk(1, 4, 1, 2, 0, 0, 0, 0, 1, 1, 1, 2, 0, 0));
      vt.push_back(mk(1, 4, 0, 0, 0, 0, 1, 4, 1, 2, 0, 0, 1, 1));
      vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 1, 2));
      vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 1, 2));

      foreach (vt[i]) run(vt[i]);

      // Underflow on queue 1 is sticky until the queue is cleared.
      chk("underflow_set",   int'(underflow), 2);
      chk("overflow_clear",  int'(overflow), 0);
      run(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      chk("underflow_clr",   int'(underflow), 0);
      run(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0));

      // Fill queue 0 to all-ones, then push once more to saturate.
      for (int i = 1; i <= MAXV; i++)
         run(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, i, 0, 0, 0, 0));
      chk("overflow_before", int'(overflow), 0);
      run(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, MAXV, 0, 0, 0, 0));
      chk("overflow_set",    int'(overflow), 1);
      run(mk(1, 0, 1, 0, 0, 0, 0, 0, 1, MAXV, 1, MAXV - 1, 0, 0));
      chk("overflow_sticky", int'(overflow), 1);
      run(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, MAXV - 1));
      run(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      chk("overflow_init_clr", int'(overflow), 0);

      // An update, then reset together with another update: the second result never appears.
      run(mk(1, 2, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0));
      dst_update = 1'b1; dst_oq = 3'd2;
      src_update = 1'b1; src_oq = 3'd5;
      reset = 1'b1;
      @(posedge clk);
      #1;
      idle();
      reset = 1'b0;
      chk("rst_dst_done", int'(dst_num_pkts_in_q_done), 0);
      chk("rst_src_done", int'(src_num_pkts_in_q_done), 0);
      chk("rst_dst_val",  int'(dst_num_pkts_in_q), 0);
      for (int q = 0; q < NQ; q++)
         run(mk(0, 0, 0, 0, 0, 0, 1, q, 0, 0, 0, 0, 1, 0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
